des_iter_core: RTL and testbench



---
 rtl/des_iter_core.sv | 243 ++++++++++++++++++++++++
 tb/tb_des_iter_core.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt engine, ECB or CBC, ROUNDS_PER_CYCLE Feistel rounds per clock.
// Latency: out_valid rises 16/ROUNDS_PER_CYCLE edges after the accept edge; one block in flight.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until that handshake.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_key/in_decrypt/in_cbc accept a
//        block; iv_load/iv_data load the chain register in IDLE; out_valid/out_ready/out_data return it.
module des_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    input  logic        in_cbc,
    input  logic        iv_load,
    input  logic [63:0] iv_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
              ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
            $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] RPC5   = 5'(ROUNDS_PER_CYCLE);

    // Permutation tables hold 1-based DES bit numbers (bit 1 = MSB).
    localparam int IP_T [64] = '{58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
                                 62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
                                 57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
                                 61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
    localparam int FP_T [64] = '{40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
                                 38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
                                 36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
                                 34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
    localparam int E_T [48]  = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
                                 12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                                 24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int P_T [32]  = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                                  2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
                                  10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
                                  63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
                                  14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    localparam int PC2_T [48] = '{14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8,
                                  16, 7,27,20,13, 2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};

    // One nibble per entry, entry index = {row, col} = {b5, b0, b4..b1}, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] k);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = k[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] r);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = r[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] s_f(input logic [47:0] x);
        logic [31:0]  y;
        logic [5:0]   b;
        logic [255:0] box;
        int           n;
        y = '0;
        for (int s = 0; s < 8; s++) begin
            b   = x[6'(47 - 6 * s) -: 6];
            n   = {26'd0, b[5], b[0], b[4:1]};
            box = SBOX[3'(s)];
            y[5'(31 - 4 * s) -: 4] = box[8'(255 - 4 * n) -: 4];
        end
        return y;
    endfunction

    // Encrypt walks C1..C16 with left rotations. Decrypt starts from C0 (== C16) and walks back
    // with right rotations by the shift of the round being undone, giving K16..K1 in order.
    function automatic logic [1:0] rot_amt(input logic [4:0] rnd, input logic dec);
        logic single;
        single = (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
        if (dec && rnd == 5'd1) return 2'd0;
        return single ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] amt,
                                          input logic right);
        case ({right, amt})
            3'b001:  return {v[26:0], v[27]};
            3'b010:  return {v[25:0], v[27:26]};
            3'b101:  return {v[0], v[27:1]};
            3'b110:  return {v[1:0], v[27:2]};
            default: return v;
        endcase
    endfunction

    logic [1:0]  state;
    logic [27:0] c_reg, d_reg, c_nxt, d_nxt;
    logic [31:0] l_reg, r_reg, l_nxt, r_nxt;
    logic [4:0]  cnt;
    logic        dec_reg, cbc_reg;
    logic [63:0] chain;
    logic [63:0] pend;       // accepted ciphertext, becomes the chain after a CBC decrypt
    logic [63:0] fp_out, result, chain_src;
    logic        last_round;

    always_comb begin : round_chain
        logic [27:0] c, d;
        logic [31:0] l, r, t;
        logic [4:0]  rnd;
        logic [1:0]  amt;
        c   = c_reg;
        d   = d_reg;
        l   = l_reg;
        r   = r_reg;
        t   = '0;
        rnd = '0;
        amt = '0;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            rnd = cnt + 5'(i + 1);
            amt = rot_amt(rnd, dec_reg);
            c   = rot28(c, amt, dec_reg);
            d   = rot28(d, amt, dec_reg);
            t   = l ^ p_f(s_f(e_f(r) ^ pc2_f({c, d})));
            l   = r;
            r   = t;
        end
        c_nxt = c;
        d_nxt = d;
        l_nxt = l;
        r_nxt = r;
    end

    assign last_round = (cnt + RPC5) == 5'd16;
    assign fp_out     = fp_f({r_nxt, l_nxt});
    assign result     = (dec_reg && cbc_reg) ? (fp_out ^ chain) : fp_out;
    // An IV loaded on the accept edge already applies to that block.
    assign chain_src  = iv_load ? iv_data : chain;
    assign in_ready   = rst_n && (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            dec_reg   <= 1'b0;
            cbc_reg   <= 1'b0;
            chain     <= '0;
            pend      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iv_load) chain <= iv_data;
                    if (in_valid) begin
                        dec_reg        <= in_decrypt;
                        cbc_reg        <= in_cbc;
                        {c_reg, d_reg} <= pc1_f(in_key);
                        {l_reg, r_reg} <= ip_f((in_cbc && !in_decrypt) ? (in_data ^ chain_src)
                                                                       : in_data);
                        pend           <= in_data;
                        cnt            <= '0;
                        state          <= S_RUN;
                    end
                end
                S_RUN: begin
                    c_reg <= c_nxt;
                    d_reg <= d_nxt;
                    l_reg <= l_nxt;
                    r_reg <= r_nxt;
                    cnt   <= cnt + RPC5;
                    if (last_round) begin
                        out_data  <= result;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                        if (cbc_reg) chain <= dec_reg ? pend : fp_out;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: three engines (1, 16 and 4 rounds per clock) driven one at a time,
// each result compared with a key-schedule-first DES model plus a per-engine CBC chain model.
module tb_des_iter_core;

    localparam int NU = 3;
    localparam int LAT [NU] = '{16, 1, 4};

    logic              clk;
    logic              rst_n;
    logic [NU-1:0]     in_valid, in_decrypt, in_cbc, iv_load, out_ready;
    logic [63:0]       in_data [NU];
    logic [63:0]       in_key  [NU];
    logic [63:0]       iv_data [NU];
    wire  [NU-1:0]     in_ready, out_valid;
    wire  [63:0]       out_data [NU];

    int                checks;
    int                failures;
    logic [63:0]       m_chain [NU];

    des_iter_core #(.ROUNDS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_key(in_key[0]), .in_decrypt(in_decrypt[0]), .in_cbc(in_cbc[0]),
        .iv_load(iv_load[0]), .iv_data(iv_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]));

    des_iter_core #(.ROUNDS_PER_CYCLE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_key(in_key[1]), .in_decrypt(in_decrypt[1]), .in_cbc(in_cbc[1]),
        .iv_load(iv_load[1]), .iv_data(iv_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]));

    des_iter_core #(.ROUNDS_PER_CYCLE(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_key(in_key[2]), .in_decrypt(in_decrypt[2]), .in_cbc(in_cbc[2]),
        .iv_load(iv_load[2]), .iv_data(iv_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference DES ----------------
    localparam int ID_IP = 0, ID_FP = 1, ID_E = 2, ID_P = 3, ID_PC1 = 4, ID_PC2 = 5;
    localparam int T_IP [64] = '{58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
                                 62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
                                 57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
                                 61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
    localparam int T_FP [64] = '{40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
                                 38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
                                 36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
                                 34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
    localparam int T_E [48]  = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
                                 12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                                 24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int T_P [32]  = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                                  2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
    localparam int T_PC1 [56] = '{57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
                                  10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
                                  63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
                                  14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    localparam int T_PC2 [48] = '{14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8,
                                  16, 7,27,20,13, 2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic int tab(input int id, input int i);
        case (id)
            ID_IP:   return T_IP[i];
            ID_FP:   return T_FP[i];
            ID_E:    return T_E[i];
            ID_P:    return T_P[i];
            ID_PC1:  return T_PC1[i];
            default: return T_PC2[i];
        endcase
    endfunction

    // x holds an in_w-bit value right-aligned; result is n bits right-aligned.
    function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int n,
                                         input int id);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < n; i++) y[n - 1 - i] = x[in_w - tab(id, i)];
        return y;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] blk,
                                              input logic dec);
        logic [63:0] t;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] x;
        logic [31:0] l, r, f, nl;
        int          sh, n, idx;
        t = perm(key, 64, 56, ID_PC1);
        c = t[55:28];
        d = t[27:0];
        for (int k = 0; k < 16; k++) begin
            sh = (k == 0 || k == 1 || k == 8 || k == 15) ? 1 : 2;
            for (int j = 0; j < sh; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            t = perm({8'd0, c, d}, 56, 48, ID_PC2);
            ks[k] = t[47:0];
        end
        t = perm(blk, 64, 64, ID_IP);
        l = t[63:32];
        r = t[31:0];
        for (int k = 0; k < 16; k++) begin
            t = perm({32'd0, r}, 32, 48, ID_E);
            x = t[47:0] ^ (dec ? ks[15 - k] : ks[k]);
            f = '0;
            for (int s = 0; s < 8; s++) begin
                n   = int'(x[47 - 6 * s -: 6]);
                idx = (((n >> 5) & 1) * 2 + (n & 1)) * 16 + ((n >> 1) & 15);
                f   = (f << 4) | 32'((SB[s] >> (4 * (63 - idx))) & 256'hF);
            end
            t  = perm({32'd0, f}, 32, 32, ID_P);
            nl = r;
            r  = l ^ t[31:0];
            l  = nl;
        end
        return perm({r, l}, 64, 64, ID_FP);
    endfunction

    // ---------------- checking and driving ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Random junk on every input of engine u; the engine must ignore it outside IDLE.
    task automatic scramble(input int u);
        in_valid[u]   = 1'($urandom);
        in_key[u]     = {$urandom, $urandom};
        in_data[u]    = {$urandom, $urandom};
        in_decrypt[u] = 1'($urandom);
        in_cbc[u]     = 1'($urandom);
        iv_load[u]    = 1'($urandom);
        iv_data[u]    = {$urandom, $urandom};
        out_ready[u]  = 1'($urandom);
    endtask

    // Called and returns at posedge+1 with engine u idle.
    task automatic send(input int u, input logic [63:0] key, input logic [63:0] data,
                        input logic dec, input logic cbc, input logic ivl,
                        input logic [63:0] iv, input int stall, output logic [63:0] res);
        logic [63:0] exp;
        int          lat;
        if (ivl) m_chain[u] = iv;
        if (!dec) begin
            exp = des_model(key, cbc ? (data ^ m_chain[u]) : data, 1'b0);
            if (cbc) m_chain[u] = exp;
        end else begin
            exp = des_model(key, data, 1'b1);
            if (cbc) begin
                exp        = exp ^ m_chain[u];
                m_chain[u] = data;
            end
        end
        res = '0;
        check("in_ready_idle", 64'(in_ready[u]), 64'd1);
        in_valid[u] = 1'b1; in_key[u] = key; in_data[u] = data; in_decrypt[u] = dec;
        in_cbc[u] = cbc; iv_load[u] = ivl; iv_data[u] = iv; out_ready[u] = 1'($urandom);
        @(posedge clk); #1;
        lat = 0;
        while (lat < 40) begin
            scramble(u);
            @(posedge clk); #1;
            lat++;
            check("in_ready_busy", 64'(in_ready[u]), 64'd0);
            if (out_valid[u]) break;
        end
        check("latency", 64'(lat), 64'(LAT[u]));
        if (!out_valid[u]) begin
            in_valid[u] = 1'b0;
            iv_load[u]  = 1'b0;
            return;
        end
        for (int s = 0; s < stall; s++) begin
            scramble(u);
            out_ready[u] = 1'b0;
            in_valid[u]  = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid[u]), 64'd1);
            check("hold_data", out_data[u], exp);
            check("hold_in_ready", 64'(in_ready[u]), 64'd0);
        end
        res = out_data[u];
        check("result", out_data[u], exp);
        scramble(u);
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        iv_load[u]  = 1'b0;
        check("post_valid", 64'(out_valid[u]), 64'd0);
        check("post_in_ready", 64'(in_ready[u]), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [64-1:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [64-1:0] P0  = 64'h0123456789ABCDEF;
    localparam logic [64-1:0] P1  = 64'h1111111111111111;
    localparam logic [64-1:0] IV  = 64'hFEDCBA9876543210;
    localparam logic [64-1:0] K2  = 64'h0E329232EA6D0D73;

    initial begin
        logic [63:0] res, c0, c1;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = '0; in_decrypt = '0; in_cbc = '0; iv_load = '0; out_ready = '0;
        for (int u = 0; u < NU; u++) begin
            in_data[u] = '0; in_key[u] = '0; iv_data[u] = '0; m_chain[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) begin
            check("rst_in_ready", 64'(in_ready[u]), 64'd0);
            check("rst_out_valid", 64'(out_valid[u]), 64'd0);
            check("rst_out_data", out_data[u], 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk); #1;

        // Known-answer vectors, with input junk during the run.
        send(0, K1, P0, 1'b0, 1'b0, 1'b0, '0, 0, res);
        check("kat_enc_rpc1", res, 64'h85E813540F0AB405);
        send(0, K2, 64'd0, 1'b1, 1'b0, 1'b0, '0, 0, res);
        check("kat_dec_rpc1", res, 64'h8787878787878787);
        send(1, K2, 64'd0, 1'b1, 1'b0, 1'b0, '0, 0, res);
        check("kat_dec_rpc16", res, 64'h8787878787878787);
        send(2, K1, P0, 1'b0, 1'b0, 1'b0, '0, 1, res);
        check("kat_enc_rpc4", res, 64'h85E813540F0AB405);

        // CBC round trip, with a 5-cycle output stall on the second block.
        send(0, K1, P0, 1'b0, 1'b1, 1'b1, IV, 0, c0);
        send(0, K1, P1, 1'b0, 1'b1, 1'b0, '0, 5, c1);
        send(0, K1, c0, 1'b1, 1'b1, 1'b1, IV, 2, res);
        check("cbc_rt_blk0", res, P0);
        send(0, K1, c1, 1'b1, 1'b1, 1'b0, '0, 0, res);
        check("cbc_rt_blk1", res, P1);

        // Reset after 7 rounds of a CBC block whose IV was just loaded.
        in_valid[0] = 1'b1; in_key[0] = K2; in_data[0] = P1; in_decrypt[0] = 1'b0;
        in_cbc[0] = 1'b1; iv_load[0] = 1'b1; iv_data[0] = IV;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; iv_load[0] = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("mid_run_in_ready", 64'(in_ready[0]), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready[0]), 64'd0);
        for (int u = 0; u < NU; u++) m_chain[u] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", 64'(in_ready[0]), 64'd1);
        check("mid_rel_out_data", out_data[0], 64'd0);
        @(posedge clk); #1;
        // With the chain cleared, CBC encryption equals plain ECB.
        send(0, K1, P0, 1'b0, 1'b1, 1'b0, '0, 0, res);
        check("post_rst_cbc", res, 64'h85E813540F0AB405);

        // Random blocks on every engine.
        for (int u = 0; u < NU; u++) begin
            for (int n = 0; n < 12; n++) begin
                send(u, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0), {$urandom, $urandom}, $urandom_range(0, 3), res);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
